// File: rtl/b2a_packet_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// b2a_packet_scheduler_pkg
//   Shared definitions for the B2A packet scheduler:
//   - packet length codes (`PACKET_LENGTH_*), normally provided by the
//     project packet parameter file; defaults are supplied here if absent
//   - FSM state encodings
//   - header field positions
//   - len_decode(): header length code -> payload word count
// -----------------------------------------------------------------------------
`ifndef PACKET_LENGTH_WIDTH
`define PACKET_LENGTH_WIDTH 4
`define PACKET_LENGTH_257   4'h1
`define PACKET_LENGTH_514   4'h2
`define PACKET_LENGTH_771   4'h3
`define PACKET_LENGTH_1028  4'h4
`endif

package b2a_packet_scheduler_pkg;

   // FSM states
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ARB     = 3'd1;
   localparam logic [2:0] S_HEADER  = 3'd2;
   localparam logic [2:0] S_PAYLOAD = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;

   // Header field positions
   localparam int HDR_CODE_MSB = 27;
   localparam int HDR_CODE_LSB = 24;
   localparam int HDR_SLEN_MSB = 23;
   localparam int HDR_SLEN_LSB = 15;

   localparam int LEN_W = 11;

   // Unknown codes fall back to the largest packet so a source never
   // gets truncated.
   function automatic logic [LEN_W-1:0] len_decode(
      input logic [`PACKET_LENGTH_WIDTH-1:0] code,
      input logic [8:0]                      slen
   );
      case (code)
         `PACKET_LENGTH_257:  return {2'b00, slen};
         `PACKET_LENGTH_514:  return 11'd512;
         `PACKET_LENGTH_771:  return 11'd768;
         `PACKET_LENGTH_1028: return 11'd1024;
         default:             return 11'd1024;
      endcase
   endfunction

endpackage

// File: rtl/b2a_rr_arbiter.sv
// -----------------------------------------------------------------------------
// b2a_rr_arbiter
//   Combinational round-robin pick: first set bit of req at or after rr_ptr,
//   wrapping at NUM_REQ.
// Ports:
//   req         in  NUM_REQ  pending requests
//   rr_ptr      in  ID_W     highest-priority index
//   grant_next  out NUM_REQ  one-hot winner (0 when no request)
//   id_next     out ID_W     winner index
// -----------------------------------------------------------------------------
module b2a_rr_arbiter
   import b2a_packet_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = 3
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    rr_ptr,
   output logic [NUM_REQ-1:0] grant_next,
   output logic [ID_W-1:0]    id_next
);

   logic          w_found;
   logic [ID_W:0] w_idx;

   // Outer loop walks priority order, inner loop matches the index with a
   // constant bit select so no variable-width index is needed.
   always_comb begin
      grant_next = '0;
      id_next    = '0;
      w_found    = 1'b0;
      w_idx      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (w_idx >= (ID_W+1)'(NUM_REQ))
            w_idx = w_idx - (ID_W+1)'(NUM_REQ);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[i] && (w_idx == (ID_W+1)'(i))) begin
               w_found       = 1'b1;
               grant_next[i] = 1'b1;
               id_next       = ID_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/b2a_packet_scheduler.sv
// -----------------------------------------------------------------------------
// b2a_packet_scheduler
//   Bob-side writer for the shared B2A packet FIFO. Round-robin arbitrates
//   NUM_REQ packet sources, writes the winner's header and then exactly the
//   payload length encoded in it. Packets never interleave.
// Optional feature: define B2A_SCHED_STATS_EN to add pkt_cnt / stall_cnt.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   req/hdr                 per-source packet request and 32-bit header
//   src_valid/src_data      per-source payload stream
//   src_ready               payload accept (combinational, granted source only)
//   grant/grant_id          registered one-hot grant and its index
//   B_B2A_wr_clk/_en/_din   FIFO write side, B_B2A_full FIFO full
//   busy                    FSM not idle
//   pkt_done                1-cycle pulse after the last payload word
//   pkt_cnt/stall_cnt       (stats build) packets done / full-stall cycles
// -----------------------------------------------------------------------------
module b2a_packet_scheduler
   import b2a_packet_scheduler_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = 3
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [32*NUM_REQ-1:0] hdr,
   input  logic [NUM_REQ-1:0]    src_valid,
   input  logic [32*NUM_REQ-1:0] src_data,
   output logic [NUM_REQ-1:0]    src_ready,
   output logic [NUM_REQ-1:0]    grant,
   output logic [ID_W-1:0]       grant_id,
   output logic                  B_B2A_wr_clk,
   output logic                  B_B2A_wr_en,
   output logic [31:0]           B_B2A_wr_din,
   input  logic                  B_B2A_full,
   output logic                  busy,
   output logic                  pkt_done
`ifdef B2A_SCHED_STATS_EN
  ,output logic [15:0]           pkt_cnt,
   output logic [15:0]           stall_cnt
`endif
);

   logic [2:0]         r_state;
   logic [NUM_REQ-1:0] r_grant;
   logic [ID_W-1:0]    r_grant_id;
   logic [ID_W-1:0]    r_rr_ptr;
   logic [31:0]        r_hdr;
   logic [LEN_W-1:0]   r_len;
   logic [LEN_W-1:0]   r_cnt;

   logic [NUM_REQ-1:0] w_grant_next;
   logic [ID_W-1:0]    w_id_next;
   logic [31:0]        w_sel_hdr;
   logic [31:0]        w_g_data;
   logic               w_g_valid;
   logic               w_hdr_wr;
   logic               w_pay_wr;

   b2a_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .req        (req),
      .rr_ptr     (r_rr_ptr),
      .grant_next (w_grant_next),
      .id_next    (w_id_next)
   );

   // One-hot AND-OR muxes: arbiter winner's header, granted source's stream
   always_comb begin
      w_sel_hdr = '0;
      w_g_data  = '0;
      w_g_valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_grant_next[i]) w_sel_hdr = w_sel_hdr | hdr[32*i +: 32];
         if (r_grant[i]) begin
            w_g_data  = w_g_data | src_data[32*i +: 32];
            w_g_valid = w_g_valid | src_valid[i];
         end
      end
   end

   assign w_hdr_wr = (r_state == S_HEADER) && !B_B2A_full;
   assign w_pay_wr = (r_state == S_PAYLOAD) && w_g_valid && !B_B2A_full;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_grant    <= '0;
         r_grant_id <= '0;
         r_rr_ptr   <= '0;
         r_hdr      <= '0;
         r_len      <= '0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (|req) r_state <= S_ARB;
            S_ARB: begin
               // req is held until pkt_done, but fall back to IDLE if it vanished
               if (|w_grant_next) begin
                  r_grant    <= w_grant_next;
                  r_grant_id <= w_id_next;
                  r_hdr      <= w_sel_hdr;
                  r_len      <= len_decode(w_sel_hdr[HDR_CODE_MSB:HDR_CODE_LSB],
                                           w_sel_hdr[HDR_SLEN_MSB:HDR_SLEN_LSB]);
                  r_state    <= S_HEADER;
               end else begin
                  r_state    <= S_IDLE;
               end
            end
            S_HEADER: if (w_hdr_wr) r_state <= (r_len == '0) ? S_DONE : S_PAYLOAD;
            S_PAYLOAD: begin
               if (w_pay_wr) begin
                  r_cnt <= r_cnt + LEN_W'(1);
                  if (r_cnt == r_len - LEN_W'(1)) r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_grant  <= '0;
               r_cnt    <= '0;
               r_rr_ptr <= (r_grant_id == ID_W'(NUM_REQ-1)) ? '0 : r_grant_id + ID_W'(1);
               r_state  <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Write strobes are decoded from state so an async reset clears them at once
   assign B_B2A_wr_clk = clk;
   assign B_B2A_wr_en  = w_hdr_wr | w_pay_wr;
   assign B_B2A_wr_din = w_hdr_wr ? r_hdr : (w_pay_wr ? w_g_data : 32'h0);
   assign src_ready    = ((r_state == S_PAYLOAD) && !B_B2A_full) ? r_grant : '0;
   assign grant        = r_grant;
   assign grant_id     = r_grant_id;
   assign busy         = (r_state != S_IDLE);
   assign pkt_done     = (r_state == S_DONE);

`ifdef B2A_SCHED_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (r_state == S_DONE) pkt_cnt <= pkt_cnt + 16'd1;
         if (((r_state == S_HEADER) || (r_state == S_PAYLOAD)) && B_B2A_full &&
             (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
